dso_acq_ctrl: RTL and testbench

DSO_ACQ_CTRL -- requirements
Module: dso_acq_ctrl

---
 rtl/dso_acq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dso_acq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dso_acq_ctrl.sv
// Oscilloscope acquisition controller: streams ADC samples into a circular
// capture buffer, keeps pre_len samples of history before the trigger, and
// fills the rest of the DEPTH-sample frame after it.
//
// Handshake: ad_valid is a one-cycle strobe and there is no back-pressure.
// A sample is accepted when ad_valid is high in PRE, WAIT_TRIG or POST and
// abort is low. Every accepted sample appears on the write port exactly one
// cycle later, as a one-cycle wr_en with its wr_addr and wr_data.
module dso_acq_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int AUTO_TMO = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_auto,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              rd_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              frame_ready,
  output logic              busy,
  output logic              trig_forced,
  // FSM state: 0 IDLE, 1 PRE, 2 WAIT_TRIG, 3 POST, 4 READY
  output logic [2:0]        state_dbg
);

  localparam int TMO_W = $clog2(AUTO_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(AUTO_TMO);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_WAIT  = 3'd2,
    S_POST  = 3'd3,
    S_READY = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Settings captured at arm so the frame is immune to later input changes
  logic [ADDR_W-1:0] pre_len_q;
  logic [DATA_W-1:0] level_q;
  logic              edge_q;
  logic              auto_q;

  logic [ADDR_W-1:0] sample_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid;
  logic [ADDR_W-1:0] wr_ptr;

  logic              in_acq;
  logic              accept;
  logic              do_arm;
  logic              rising;
  logic              falling;
  logic              trig_real;
  logic              trig_tmo;
  logic              trig_hit;
  logic [ADDR_W-1:0] post_len;

  // Samples after the trigger sample: DEPTH-1-pre_len, i.e. the complement
  assign post_len = ~pre_len_q;

  assign in_acq  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign accept  = in_acq && ad_valid && !abort;
  assign rising  = prev_valid && (prev_q < level_q) && (ad_data >= level_q);
  assign falling = prev_valid && (prev_q > level_q) && (ad_data <= level_q);

  // A genuine edge wins over the timeout when both land on the same sample
  assign trig_real = accept && (state == S_WAIT) && (edge_q ? falling : rising);
  assign trig_tmo  = accept && (state == S_WAIT) && !trig_real && auto_q &&
                     (tmo_cnt == TMO_LAST);
  assign trig_hit  = trig_real || trig_tmo;

  assign busy        = in_acq;
  assign frame_ready = (state == S_READY);
  assign state_dbg   = state;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort is checked first so it beats arm and trigger
  always_comb begin
    state_nxt = state;
    do_arm    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) do_arm = 1'b1;
      end
      S_PRE: begin
        if (abort) state_nxt = S_IDLE;
        else if (accept && (sample_cnt == pre_len_q - ADDR_W'(1))) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort) state_nxt = S_IDLE;
        else if (trig_hit) state_nxt = (post_len == '0) ? S_READY : S_POST;
      end
      S_POST: begin
        if (abort) state_nxt = S_IDLE;
        else if (accept && (post_cnt == post_len - ADDR_W'(1))) state_nxt = S_READY;
      end
      S_READY: begin
        if (rd_done) begin
          if (arm) do_arm = 1'b1;
          else     state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (do_arm) state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
  end

  // Buffer write port and the free-running write pointer
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_ptr  <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= wr_ptr;
        wr_data <= ad_data;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Arm-time settings and previous-sample history for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre_len_q  <= '0;
      level_q    <= '0;
      edge_q     <= 1'b0;
      auto_q     <= 1'b0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
    end else if (do_arm) begin
      pre_len_q  <= pre_len;
      level_q    <= trig_level;
      edge_q     <= trig_edge;
      auto_q     <= trig_auto;
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev_q     <= ad_data;
      prev_valid <= 1'b1;
    end
  end

  // Pre-trigger, post-trigger and saturating auto-timeout counters
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sample_cnt <= '0;
      post_cnt   <= '0;
      tmo_cnt    <= '0;
    end else if (do_arm) begin
      sample_cnt <= '0;
      post_cnt   <= '0;
      tmo_cnt    <= '0;
    end else if (accept) begin
      if (state == S_PRE)  sample_cnt <= sample_cnt + ADDR_W'(1);
      if (state == S_POST) post_cnt   <= post_cnt + ADDR_W'(1);
      if ((state == S_WAIT) && !trig_hit && (tmo_cnt != TMO_MAX))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Frame origin and trigger source, captured on the trigger sample
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      start_addr  <= '0;
      trig_forced <= 1'b0;
    end else if (trig_hit) begin
      start_addr  <= wr_ptr - pre_len_q;
      trig_forced <= trig_tmo;
    end
  end

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Bench for dso_acq_ctrl: a table of complete acquisitions plus directed
// sequences for edge qualification, abort, READY handling and reset.
module tb_dso_acq_ctrl;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int AUTO_TMO = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  logic              sys_clk;
  logic              sys_rst;
  logic [DATA_W-1:0] ad_data;
  logic              ad_valid;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic              trig_auto;
  logic [ADDR_W-1:0] pre_len;
  logic              rd_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] start_addr;
  logic              frame_ready;
  logic              busy;
  logic              trig_forced;
  logic [2:0]        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected {addr, data} of every write, in order
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]        exp_ptr;

  // pat: 0 ramp up, 1 ramp down, 2 constant 50
  typedef struct {
    int         pat;
    logic [7:0] level;
    logic       edge_f;
    logic       auto_t;
    int         pre;
    int         trig_idx;
    logic       forced;
    logic       b2b;
  } vec_t;

  vec_t vt[6];

  dso_acq_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .AUTO_TMO(AUTO_TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .ad_data    (ad_data),
    .ad_valid   (ad_valid),
    .arm        (arm),
    .abort      (abort),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_auto  (trig_auto),
    .pre_len    (pre_len),
    .rd_done    (rd_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start_addr (start_addr),
    .frame_ready(frame_ready),
    .busy       (busy),
    .trig_forced(trig_forced),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every wr_en must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: wr_en=1 addr %0d data %0d, expected no write",
                 wr_addr, wr_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[ADDR_W+DATA_W-1:DATA_W]);
        check("wr_data", wr_data, e[DATA_W-1:0]);
      end
    end
  end

  function automatic logic [7:0] sample_val(input int pat, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    case (pat)
      0:       return kb;
      1:       return 8'd255 - kb;
      default: return 8'd50;
    endcase
  endfunction

  // Drivers
  task automatic drive_sample(input logic [DATA_W-1:0] v, input bit expect_wr);
    @(negedge sys_clk);
    ad_valid = 1'b1;
    ad_data  = v;
    if (expect_wr) begin
      exp_q.push_back({exp_ptr, v});
      exp_ptr = exp_ptr + 1'b1;
    end
    @(negedge sys_clk);
    ad_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge sys_clk);
  endtask

  task automatic pulse(input bit a, input bit rd, input bit ab);
    @(negedge sys_clk);
    arm     = a;
    rd_done = rd;
    abort   = ab;
    @(negedge sys_clk);
    arm     = 1'b0;
    rd_done = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic abort_with_sample(input logic [DATA_W-1:0] v);
    @(negedge sys_clk);
    abort    = 1'b1;
    ad_valid = 1'b1;
    ad_data  = v;
    @(negedge sys_clk);
    abort    = 1'b0;
    ad_valid = 1'b0;
  endtask

  task automatic configure(input logic [7:0] lvl, input logic ef, input logic au, input int pl);
    trig_level = lvl;
    trig_edge  = ef;
    trig_auto  = au;
    pre_len    = ADDR_W'(pl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},       wr_en, 0);
    check({tag, "_wr_addr"},     wr_addr, 0);
    check({tag, "_wr_data"},     wr_data, 0);
    check({tag, "_start_addr"},  start_addr, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_trig_forced"}, trig_forced, 0);
    check({tag, "_state"},       state_dbg, ST_IDLE);
  endtask

  initial begin
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] exp_start;
    int                total;

    //          pat lvl  fall auto pre   trig  forced b2b
    vt[0] = '{0, 8'd100, 1'b0, 1'b0, 256,  356,  1'b0, 1'b0};
    vt[1] = '{2, 8'd100, 1'b0, 1'b1, 0,    15,   1'b1, 1'b1};
    vt[2] = '{1, 8'd128, 1'b1, 1'b0, 10,   127,  1'b0, 1'b0};
    vt[3] = '{0, 8'd200, 1'b0, 1'b0, 1023, 1224, 1'b0, 1'b1};
    vt[4] = '{0, 8'd100, 1'b0, 1'b1, 5,    20,   1'b1, 1'b1};
    vt[5] = '{0, 8'd10,  1'b0, 1'b1, 3,    10,   1'b0, 1'b1};

    sys_rst  = 1'b1;
    ad_data  = '0;
    ad_valid = 1'b0;
    arm      = 1'b0;
    abort    = 1'b0;
    rd_done  = 1'b0;
    exp_ptr  = '0;
    configure(8'd0, 1'b0, 1'b0, 0);

    // Reset state
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Falling edge: first sample after arm never triggers; arm while busy ignored
    configure(8'd128, 1'b1, 1'b0, 0);
    drive_sample(8'd200, 0);
    pulse(1, 0, 0);
    check("fall_arm_state", state_dbg, ST_WAIT);
    base = exp_ptr;
    drive_sample(8'd0, 1);
    check("fall_first_no_trig", state_dbg, ST_WAIT);
    drive_sample(8'd130, 1);
    check("fall_130_no_trig", state_dbg, ST_WAIT);
    configure(8'd128, 1'b1, 1'b0, 7);
    pulse(1, 0, 0);
    check("arm_busy_ignored", state_dbg, ST_WAIT);
    drive_sample(8'd120, 1);
    check("fall_trig_state", state_dbg, ST_POST);
    check("fall_start_addr", start_addr, base + 10'd2);
    check("fall_trig_forced", trig_forced, 0);
    for (int i = 0; i < 3; i++) drive_sample(8'(60 + i), 1);
    abort_with_sample(8'd77);
    check("abort_post_state", state_dbg, ST_IDLE);
    check("abort_post_busy", busy, 0);
    for (int i = 0; i < 3; i++) drive_sample(8'(90 + i), 0);
    @(negedge sys_clk); #1;
    check("fall_queue_drained", exp_q.size(), 0);

    // No auto trigger: stays waiting past AUTO_TMO, then abort
    configure(8'd100, 1'b0, 1'b0, 0);
    pulse(1, 0, 0);
    for (int i = 0; i < 40; i++) drive_sample(8'd50, 1);
    check("noauto_state", state_dbg, ST_WAIT);
    check("noauto_busy", busy, 1);
    check("noauto_frame_ready", frame_ready, 0);
    abort_with_sample(8'd50);
    check("noauto_abort_state", state_dbg, ST_IDLE);
    for (int i = 0; i < 3; i++) drive_sample(8'd50, 0);
    @(negedge sys_clk); #1;
    check("noauto_queue_drained", exp_q.size(), 0);

    // Table of complete acquisitions
    for (int r = 0; r < 6; r++) begin
      total = vt[r].trig_idx + 1 + (DEPTH - 1 - vt[r].pre);
      configure(vt[r].level, vt[r].edge_f, vt[r].auto_t, vt[r].pre);
      if (!vt[r].b2b && r > 0) begin
        pulse(0, 1, 0);
        check("rd_done_to_idle", state_dbg, ST_IDLE);
      end
      base = exp_ptr;
      pulse(1, vt[r].b2b, 0);
      check("arm_state", state_dbg, (vt[r].pre == 0) ? ST_WAIT : ST_PRE);
      check("arm_busy", busy, 1);
      for (int k = 0; k < total; k++) drive_sample(sample_val(vt[r].pat, k), 1);
      @(negedge sys_clk); #1;
      exp_start = base + ADDR_W'(vt[r].trig_idx - vt[r].pre);
      check("frame_ready", frame_ready, 1);
      check("ready_state", state_dbg, ST_READY);
      check("ready_busy", busy, 0);
      check("start_addr", start_addr, exp_start);
      check("trig_forced", trig_forced, vt[r].forced);
      check("frame_queue_drained", exp_q.size(), 0);
      for (int i = 0; i < 2; i++) drive_sample(8'd33, 0);
      check("ready_held", frame_ready, 1);
    end

    // abort in READY is ignored
    pulse(0, 0, 1);
    check("abort_ready_state", state_dbg, ST_READY);
    check("abort_ready_frame", frame_ready, 1);
    pulse(0, 1, 0);
    check("final_rd_done", state_dbg, ST_IDLE);

    // Reset in POST: outputs clear asynchronously, no writes until next arm
    configure(8'd10, 1'b0, 1'b0, 0);
    pulse(1, 0, 0);
    for (int k = 0; k < 15; k++) drive_sample(sample_val(0, k), 1);
    check("rst_pre_post_state", state_dbg, ST_POST);
    @(negedge sys_clk); #1;
    check("rst_queue_drained", exp_q.size(), 0);
    #1;
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_ptr = '0;
    for (int i = 0; i < 2; i++) drive_sample(8'd44, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_sample(8'd45, 0);
    check("after_rst_state", state_dbg, ST_IDLE);
    check("after_rst_wr_en", wr_en, 0);
    pulse(1, 0, 0);
    for (int i = 0; i < 3; i++) drive_sample(8'(i + 1), 1);
    pulse(0, 0, 1);
    check("after_rst_abort", state_dbg, ST_IDLE);
    @(negedge sys_clk); #1;
    check("end_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
